// File: rtl/lake_config_loader.sv
// Word-addressed config responder: shadow register file, single-cycle commit
// into the active config_memory vector, and read-back of shadow/status/size.
module lake_cfg_word #(
  parameter int              DW   = 32,
  parameter logic [DW-1:0]   MASK = '1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (we) q <= wdata & MASK;
  end
endmodule

module lake_config_loader #(
  parameter int CONFIG_MEMORY_SIZE = 512,
  parameter int CONFIG_DATA_WIDTH  = 32,
  parameter int CONFIG_ADDR_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CONFIG_ADDR_WIDTH-1:0]  config_addr,
  input  logic [CONFIG_DATA_WIDTH-1:0]  config_data,
  input  logic                          config_write,
  input  logic                          config_read,
  output logic [CONFIG_DATA_WIDTH-1:0]  config_rd_data,
  output logic                          config_rd_valid,
  output logic                          config_err,
  output logic                          config_commit,
  output logic [CONFIG_MEMORY_SIZE-1:0] config_memory
);
  localparam int MS        = CONFIG_MEMORY_SIZE;
  localparam int DW        = CONFIG_DATA_WIDTH;
  localparam int AW        = CONFIG_ADDR_WIDTH;
  localparam int NUM_WORDS = (MS + DW - 1) / DW;

  // Bits of word k that lie beyond MS are never stored, so they read back as 0.
  function automatic logic [DW-1:0] word_mask(input int k);
    logic [DW-1:0] m;
    for (int b = 0; b < DW; b++) m[b] = ((k * DW + b) < MS);
    return m;
  endfunction

  logic [NUM_WORDS-1:0][DW-1:0] shadow;
  logic [NUM_WORDS*DW-1:0]      shadow_flat;
  logic [NUM_WORDS-1:0]         wr_word;
  logic                         is_word, is_ctrl, is_size;
  logic                         commit_req, dirty, committed;
  logic [DW-1:0]                rd_mux;

  // Full-width compares: upper address bits never alias onto low words.
  assign is_word    = config_addr <  AW'(NUM_WORDS);
  assign is_ctrl    = config_addr == AW'(NUM_WORDS);
  assign is_size    = config_addr == AW'(NUM_WORDS + 1);
  assign commit_req = config_write && is_ctrl && config_data[0];
  assign shadow_flat = shadow;

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
    assign wr_word[k] = config_write && (config_addr == AW'(k));
    lake_cfg_word #(.DW(DW), .MASK(word_mask(k))) u_word (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_word[k]),
      .wdata (config_data),
      .q     (shadow[k])
    );
  end

  // Pre-edge values are muxed, giving read-before-write on a same-cycle write.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_WORDS; k++)
      if (config_addr == AW'(k)) rd_mux = shadow[k];
    if (is_ctrl) rd_mux = DW'({dirty, committed});
    if (is_size) rd_mux = DW'(MS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      config_memory   <= '0;
      config_rd_data  <= '0;
      config_rd_valid <= 1'b0;
      config_err      <= 1'b0;
      config_commit   <= 1'b0;
      dirty           <= 1'b0;
      committed       <= 1'b0;
    end else begin
      config_rd_valid <= config_read;
      config_commit   <= commit_req;
      config_err      <= (config_write && !(is_word || is_ctrl)) ||
                         (config_read  && !(is_word || is_ctrl || is_size));
      if (config_read) config_rd_data <= rd_mux;
      if (commit_req) begin
        config_memory <= shadow_flat[MS-1:0];
        dirty         <= 1'b0;
        committed     <= 1'b1;
      end else if (|wr_word) begin
        dirty <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lake_config_loader.sv
// Bench for lake_config_loader: table-driven transactions with a read-data
// scoreboard on the default build, plus a 40-bit build for the partial word.
module tb_lake_config_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, wr, rd, rd_valid, err, commit;
  logic [31:0]  addr, data, rd_data;
  logic [511:0] mem;

  logic         b_rst, b_wr, b_rd, b_rd_valid, b_err, b_commit;
  logic [31:0]  b_addr, b_data, b_rd_data;
  logic [39:0]  b_mem;

  lake_config_loader dut (
    .clk(clk), .rst(rst), .config_addr(addr), .config_data(data),
    .config_write(wr), .config_read(rd), .config_rd_data(rd_data),
    .config_rd_valid(rd_valid), .config_err(err), .config_commit(commit),
    .config_memory(mem)
  );

  lake_config_loader #(.CONFIG_MEMORY_SIZE(40)) dut40 (
    .clk(clk), .rst(b_rst), .config_addr(b_addr), .config_data(b_data),
    .config_write(b_wr), .config_read(b_rd), .config_rd_data(b_rd_data),
    .config_rd_valid(b_rd_valid), .config_err(b_err), .config_commit(b_commit),
    .config_memory(b_mem)
  );

  int total = 0, bad = 0;
  logic [31:0] expq[$];

  typedef struct {
    logic        wr, rd;
    logic [31:0] addr, data;
    logic        err, cmt;
    logic [31:0] rdata;
    string       nm;
  } vec_t;
  vec_t vt[$];

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic add(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                     input logic e, input logic c, input logic [31:0] rdv, input string nm);
    vec_t v;
    v.wr = w; v.rd = r; v.addr = a; v.data = d; v.err = e; v.cmt = c; v.rdata = rdv; v.nm = nm;
    vt.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    wr = v.wr; rd = v.rd; addr = v.addr; data = v.data;
    if (v.rd) expq.push_back(v.rdata);
    cyc();
    wr = 1'b0; rd = 1'b0;
    check({v.nm, "_err"}, err, v.err);
    check({v.nm, "_cmt"}, commit, v.cmt);
  endtask

  // Scoreboard: every rd_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon
    logic [31:0] e;
    if (rd_valid === 1'b1) begin
      if (expq.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_unexpected: got valid data %0h want no valid", rd_data);
      end else begin
        e = expq.pop_front();
        check("rd_data", rd_data, e);
      end
    end
  end

  initial begin
    rst = 1; wr = 0; rd = 0; addr = 0; data = 0;
    b_rst = 1; b_wr = 0; b_rd = 0; b_addr = 0; b_data = 0;
    cyc(); cyc();
    rst = 0; b_rst = 0;
    repeat (5) cyc();
    check("rst_mem", mem, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_err", err, 0);
    check("rst_commit", commit, 0);

    add(0, 1, 16, 0, 0, 0, 32'h0, "stat_rst");
    for (int k = 0; k < 16; k++) add(1, 0, k, 32'h1000 + k, 0, 0, 0, "load");
    add(0, 1, 16, 0, 0, 0, 32'h2, "stat_dirty");
    add(1, 0, 16, 1, 0, 1, 0, "commit");
    add(0, 1, 16, 0, 0, 0, 32'h1, "stat_clean");
    add(0, 1, 17, 0, 0, 0, 32'h200, "size");
    add(1, 1, 5, 32'hBEEF, 0, 0, 32'h1005, "rbw");
    add(0, 1, 5, 0, 0, 0, 32'hBEEF, "rd5");
    add(1, 0, 18, 32'hDEAD, 1, 0, 0, "wr_ill");
    add(0, 1, 32'h0001_0000, 0, 1, 0, 0, "rd_ill");
    add(1, 0, 17, 5, 1, 0, 0, "wr_size");
    add(0, 1, 17, 0, 0, 0, 32'h200, "size2");
    add(1, 0, 32'h0001_0000, 32'h55, 1, 0, 0, "wr_alias");
    add(0, 1, 0, 0, 0, 0, 32'h1000, "rd0");
    add(1, 0, 16, 0, 0, 0, 0, "ctrl_noop");
    add(0, 1, 16, 0, 0, 0, 32'h3, "stat_both");
    add(1, 0, 16, 1, 0, 1, 0, "commit2");
    add(0, 1, 16, 0, 0, 0, 32'h1, "stat2");
    add(1, 0, 16, 3, 0, 1, 0, "commit_clean");
    add(0, 1, 16, 0, 0, 0, 32'h1, "stat3");

    for (int i = 0; i < 18; i++) apply(vt[i]);
    check("mem_precommit", mem, 0);
    apply(vt[18]);
    check("mem_w0", mem[31:0], 32'h1000);
    check("mem_w15", mem[511:480], 32'h100F);
    cyc();
    check("commit_pulse_end", commit, 0);
    for (int i = 19; i < vt.size(); i++) apply(vt[i]);
    cyc();
    check("mem_w5", mem[191:160], 32'hBEEF);
    wr = 1; addr = 2; data = 32'h7777; cyc(); wr = 0;
    cyc();
    check("mem_no_direct", mem[95:64], 32'h1002);

    // Read latency and hold
    rd = 1; addr = 3; expq.push_back(32'h1003); cyc(); rd = 0;
    check("lat_valid", rd_valid, 1);
    check("lat_data", rd_data, 32'h1003);
    cyc();
    check("lat_valid_off", rd_valid, 0);
    check("lat_hold", rd_data, 32'h1003);

    // Reset beats a simultaneous read; no valid follows it
    rd = 1; addr = 0; rst = 1; cyc(); rd = 0;
    check("rstrd_valid", rd_valid, 0);
    check("rstrd_mem", mem, 0);
    cyc(); rst = 0; cyc();
    check("rstrd_valid2", rd_valid, 0);
    rd = 1; addr = 16; expq.push_back(0); cyc(); rd = 0;
    rd = 1; addr = 0; expq.push_back(0); cyc(); rd = 0;
    cyc();

    // 40-bit build: partial last word
    b_wr = 1; b_addr = 1; b_data = 32'hFFFF_FFFF; cyc(); b_wr = 0;
    check("b_precommit", b_mem, 0);
    b_wr = 1; b_addr = 2; b_data = 1; cyc(); b_wr = 0;
    check("b_commit", b_commit, 1);
    check("b_mem", b_mem, 40'hFF_0000_0000);
    b_rd = 1; b_addr = 1; cyc(); b_rd = 0;
    check("b_rd_valid", b_rd_valid, 1);
    check("b_rd_w1", b_rd_data, 32'h0000_00FF);
    b_rd = 1; b_addr = 3; cyc(); b_rd = 0;
    check("b_size", b_rd_data, 32'd40);
    b_rd = 1; b_addr = 4; cyc(); b_rd = 0;
    check("b_ill_err", b_err, 1);
    b_wr = 1; b_addr = 0; b_data = 32'h1234_5678; cyc(); b_wr = 0;
    b_rst = 1; cyc(); cyc(); b_rst = 0;
    check("b_rst_mem", b_mem, 0);
    check("b_rst_valid", b_rd_valid, 0);
    b_rd = 1; b_addr = 1; cyc(); b_rd = 0;
    check("b_rst_w1", b_rd_data, 0);
    b_rd = 1; b_addr = 0; cyc(); b_rd = 0;
    check("b_rst_w0", b_rd_data, 0);
    b_rd = 1; b_addr = 2; cyc(); b_rd = 0;
    check("b_rst_stat", b_rd_data, 0);

    cyc();
    check("q_empty", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
